// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared state enum, default sizes and round-robin pick helper for mult_arbiter
package mult_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH = 8;
  localparam int MAX_REQ = 8;
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    rr_pick = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: requester bus (req/op_a/op_b in, grant/rsp_* out), busy and multiplier handshake; master = arbiter, slave = clients+multiplier; rsp_err only with MULT_ARB_TIMEOUT_EN
interface mult_arbiter_if import mult_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH = DEF_WIDTH
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*WIDTH-1:0] op_a;
  logic [NUM_REQ*WIDTH-1:0] op_b;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [2*WIDTH-1:0] rsp_product;
  logic busy;
  logic mul_start;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] mul_product;
  logic mul_done;
`ifdef MULT_ARB_TIMEOUT_EN
  logic rsp_err;
  modport master(input req, op_a, op_b, mul_product, mul_done,
                 output grant, rsp_valid, rsp_product, busy, mul_start, mul_a, mul_b, rsp_err);
  modport slave(output req, op_a, op_b, mul_product, mul_done,
                input grant, rsp_valid, rsp_product, busy, mul_start, mul_a, mul_b, rsp_err);
`else
  modport master(input req, op_a, op_b, mul_product, mul_done,
                 output grant, rsp_valid, rsp_product, busy, mul_start, mul_a, mul_b);
  modport slave(output req, op_a, op_b, mul_product, mul_done,
                input grant, rsp_valid, rsp_product, busy, mul_start, mul_a, mul_b);
`endif
endinterface

// File: rtl/mult_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin winner from req starting at ptr; ptr advances past the winner on advance (clock, reset_n async active-high)
module rr_arbiter import mult_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [2:0]         winner
);
  logic [2:0] ptr;
  logic [MAX_REQ-1:0] req_ext;
  assign req_ext = MAX_REQ'(req);
  assign winner = rr_pick(req_ext, ptr);
  always_ff @(posedge clock or posedge reset_n)
    if (reset_n) ptr <= '0;
    else if (advance) ptr <= winner == 3'(NUM_REQ - 1) ? 3'd0 : winner + 3'd1;
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one sequential multiplier; ports clock, reset_n (async active-high), bus (mult_arbiter_if.master); MULT_ARB_TIMEOUT_EN adds an ISSUE watchdog and rsp_err
module mult_arbiter import mult_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH = DEF_WIDTH
`ifdef MULT_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input logic clock,
  input logic reset_n,
  mult_arbiter_if.master bus
);
  state_t state, state_d;
  logic [2:0] winner;
  logic grant_now;
  logic fin;
  assign grant_now = state == IDLE && |bus.req;
  assign bus.busy = state != IDLE;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clock(clock),
    .reset_n(reset_n),
    .req(bus.req),
    .advance(grant_now),
    .winner(winner)
  );
`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic expired;
  assign expired = cnt == CW'(TIMEOUT - 1);
  assign fin = bus.mul_done || expired;
  always_ff @(posedge clock or posedge reset_n)
    if (reset_n) cnt <= '0;
    else cnt <= state == ISSUE ? cnt + CW'(1) : '0;
  always_ff @(posedge clock or posedge reset_n)
    if (reset_n) bus.rsp_err <= 1'b0;
    else bus.rsp_err <= state == ISSUE && !bus.mul_done && expired;
`else
  assign fin = bus.mul_done;
`endif
  always_ff @(posedge clock or posedge reset_n)
    if (reset_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    state_d = state == IDLE  ? (grant_now ? ISSUE : IDLE) :
              state == ISSUE ? (fin ? RELEASE : ISSUE) :
                               (bus.mul_done ? RELEASE : IDLE);
  end
  always_ff @(posedge clock or posedge reset_n)
    if (reset_n) begin
      bus.grant <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_product <= '0;
      bus.mul_start <= 1'b0;
      bus.mul_a <= '0;
      bus.mul_b <= '0;
    end else begin
      bus.rsp_valid <= '0;
      if (grant_now) begin
        bus.grant <= NUM_REQ'(1) << winner;
        bus.mul_a <= bus.op_a[winner*WIDTH +: WIDTH];
        bus.mul_b <= bus.op_b[winner*WIDTH +: WIDTH];
        bus.mul_start <= 1'b1;
      end
      if (state == ISSUE && fin) begin
        bus.rsp_valid <= bus.grant;
        bus.rsp_product <= bus.mul_done ? bus.mul_product : '0;
        bus.mul_start <= 1'b0;
      end
      if (state == RELEASE && !bus.mul_done) bus.grant <= '0;
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: scoreboard bench for mult_arbiter with a behavioural shift-add multiplier
module tb_mult_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  typedef struct packed {
    logic [1:0] idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] p;
    logic err;
  } exp_t;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic [N-1:0] hold = '0;
  logic stall = 1'b0;
  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;
  int n_rsp = 0;
  int issue_cyc = 0;
  logic m_run;
  logic [3:0] m_cnt;
  logic [2*W-1:0] m_ash;
  logic [2*W-1:0] m_acc;
  logic [W-1:0] m_b;
  always #5 clock = ~clock;
  mult_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
  mult_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      m_run <= 1'b0;
      m_cnt <= '0;
      m_ash <= '0;
      m_acc <= '0;
      m_b <= '0;
      bus.mul_done <= 1'b0;
      bus.mul_product <= '0;
    end else if (m_run) begin
      m_acc <= m_acc + (m_b[0] ? m_ash : '0);
      m_ash <= m_ash << 1;
      m_b <= m_b >> 1;
      m_cnt <= m_cnt - 4'd1;
      if (m_cnt == 4'd1) begin
        m_run <= 1'b0;
        bus.mul_done <= 1'b1;
        bus.mul_product <= m_acc + (m_b[0] ? m_ash : '0);
      end
    end else if (bus.mul_done) begin
      if (!bus.mul_start) bus.mul_done <= 1'b0;
    end else if (bus.mul_start && !stall) begin
      m_run <= 1'b1;
      m_cnt <= 4'(W);
      m_ash <= {{W{1'b0}}, bus.mul_a};
      m_b <= bus.mul_b;
      m_acc <= '0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic queue_txn(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic err);
    bus.op_a[i*W +: W] = a;
    bus.op_b[i*W +: W] = b;
    sb.push_back('{idx: 2'(i), a: a, b: b, p: err ? '0 : (2*W)'(a) * (2*W)'(b), err: err});
  endtask
  task automatic step;
    exp_t e;
    @(negedge clock);
    if (bus.mul_start) issue_cyc++;
    if (bus.mul_start && sb.size() != 0) begin
      chk("grant", 32'(bus.grant), 32'(4'b1 << sb[0].idx));
      chk("mul_a", 32'(bus.mul_a), 32'(sb[0].a));
      chk("mul_b", 32'(bus.mul_b), 32'(sb[0].b));
    end
    if (bus.rsp_valid != 0) begin
      if (sb.size() == 0) chk("extra_rsp", 32'(bus.rsp_valid), 32'd0);
      else begin
        e = sb.pop_front();
        chk("rsp_who", 32'(bus.rsp_valid), 32'(4'b1 << e.idx));
        chk("rsp_prod", 32'(bus.rsp_product), 32'(e.p));
`ifdef MULT_ARB_TIMEOUT_EN
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
`endif
      end
      n_rsp++;
      bus.req = bus.req & ~(bus.rsp_valid & ~hold);
    end
  endtask
  task automatic drain(input int budget);
    int k = 0;
    do begin
      step();
      k++;
    end while ((sb.size() != 0 || bus.busy) && k < budget);
    chk("drain", 32'({sb.size() != 0, bus.busy}), 32'd0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_product"}, 32'(bus.rsp_product), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_mul_start"}, 32'(bus.mul_start), 32'd0);
    chk({tag, "_mul_ab"}, 32'({bus.mul_a, bus.mul_b}), 32'd0);
  endtask
  initial begin
    int k;
    int base;
    bus.req = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) queue_txn(i, W'(i + 1), W'(3), 1'b0);
    bus.req = 4'hF;
    base = n_rsp;
    drain(200);
    chk("t2_served", 32'(n_rsp - base), 32'd4);
    queue_txn(0, 8'd7, 8'd9, 1'b0);
    bus.req = 4'b0001;
    step();
    chk("lat_grant", 32'(bus.grant), 32'b0001);
    chk("lat_start", 32'(bus.mul_start), 32'd1);
    drain(100);
    chk("t1_idle", 32'(bus.busy), 32'd0);
    queue_txn(2, 8'd5, 8'd6, 1'b0);
    queue_txn(0, 8'd11, 8'd13, 1'b0);
    queue_txn(2, 8'd5, 8'd6, 1'b0);
    queue_txn(0, 8'd11, 8'd13, 1'b0);
    hold = 4'b0101;
    bus.req = 4'b0100;
    base = n_rsp;
    k = 0;
    do begin
      step();
      k++;
    end while (bus.grant == 0 && k < 20);
    bus.req = 4'b0101;
    k = 0;
    while (n_rsp < base + 4 && k < 200) begin
      step();
      k++;
    end
    bus.req = '0;
    hold = '0;
    chk("t3_count", 32'(n_rsp - base), 32'd4);
    drain(50);
    queue_txn(1, 8'hFF, 8'd0, 1'b0);
    bus.req = 4'b0010;
    drain(100);
    queue_txn(1, 8'd0, 8'hFF, 1'b0);
    bus.req = 4'b0010;
    drain(100);
    queue_txn(1, 8'd1, 8'd255, 1'b0);
    bus.req = 4'b0010;
    drain(100);
    queue_txn(3, 8'd12, 8'd12, 1'b0);
    bus.req = 4'b1000;
    repeat (4) step();
    chk("t5_in_issue", 32'(bus.mul_start), 32'd1);
    reset_n = 1'b1;
    #1;
    chk_zero("midreset");
    sb.delete();
    bus.req = '0;
    @(negedge clock);
    reset_n = 1'b0;
    repeat (3) step();
    queue_txn(3, 8'd13, 8'd14, 1'b0);
    bus.req = 4'b1000;
    drain(100);
`ifdef MULT_ARB_TIMEOUT_EN
    stall = 1'b1;
    issue_cyc = 0;
    queue_txn(1, 8'd3, 8'd3, 1'b1);
    bus.req = 4'b0010;
    drain(200);
    chk("t6_issue_cycles", 32'(issue_cyc), 32'd64);
    stall = 1'b0;
    queue_txn(1, 8'd3, 8'd3, 1'b0);
    bus.req = 4'b0010;
    drain(100);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
